bcd_scan_counter: RTL and testbench

Parametrised N-digit cascaded BCD counter with an integrated multiplexed 7-segment scan driver. It replaces the fixed pair of 4-bit counters, two dividers and per-digit decoders with one block. It adds up/down counting, synchronous load/clear, leading-zero blanking and a time-multiplexed digit output. It sits between the board clock and the 7-segment header; the count value is also exported for other logic.

---
 rtl/bcd_scan_counter_pkg.sv | 37 +++
 rtl/bcd_scan_counter_tick.sv | 27 ++
 rtl/bcd_scan_counter.sv | 113 +++++++++++
 tb/tb_bcd_scan_counter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bcd_scan_counter_pkg.sv
// Shared constants for the BCD scan counter: digit width and active-low 7-segment patterns.
// Bit 0 of a pattern drives segment a, bit 6 drives segment g.
package bcd_scan_counter_pkg;

   localparam int BCD_W = 4;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bcd_scan_counter_tick.sv
// Free-running prescaler 0..DIV; tick is high for the single cycle the counter equals DIV.
// Latency: tick is combinational from the counter register; no backpressure.
module tick_gen #(
   parameter int DIV = 3
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int W = (DIV < 1) ? 1 : $clog2(DIV + 1);

   logic [W-1:0] cnt;

   assign tick = (cnt == W'(DIV));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/bcd_scan_counter.sv
// N-digit up/down BCD counter with clamped load, clear and a multiplexed 7-segment scan driver.
// count/carry_out update on the edge ending a count tick; seg/dig_sel lag index/count by one cycle.
module bcd_scan_counter
   import bcd_scan_counter_pkg::*;
#(
   parameter int N_DIGITS  = 4,
   parameter int DIV_COUNT = 24_999_999,
   parameter int DIV_SCAN  = 24_999,
   parameter int BLANK_LZ  = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ena,
   input  logic                      up_dn,
   input  logic                      clear,
   input  logic                      load,
   input  logic [BCD_W*N_DIGITS-1:0] load_val,
   output logic [BCD_W*N_DIGITS-1:0] count,
   output logic                      carry_out,
   output logic [6:0]                seg,
   output logic [N_DIGITS-1:0]       dig_sel
);

   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   logic                      cnt_tick;
   logic                      scan_tick;
   logic [BCD_W*N_DIGITS-1:0] cnt_nxt;
   logic [BCD_W*N_DIGITS-1:0] ld_val;
   logic [N_DIGITS-1:0]       eq9;
   logic [N_DIGITS-1:0]       eq0;
   logic [N_DIGITS-1:0]       blank_v;
   logic [BCD_W-1:0]          digs [N_DIGITS];
   logic                      wrap;
   logic [IW-1:0]             scan_idx;

   tick_gen #(.DIV(DIV_COUNT)) u_count_tick (.clk(clk), .rst(rst), .tick(cnt_tick));
   tick_gen #(.DIV(DIV_SCAN))  u_scan_tick  (.clk(clk), .rst(rst), .tick(scan_tick));

   // Lower-digit conditions are reduced from eq9/eq0 masks rather than chained digit to digit.
   for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
      localparam logic [N_DIGITS-1:0] LOW_MASK = (N_DIGITS'(1) << k) - N_DIGITS'(1);

      logic [BCD_W-1:0] d;
      logic [BCD_W-1:0] lv;
      logic             lo9;
      logic             lo0;

      assign d       = count[k*BCD_W +: BCD_W];
      assign digs[k] = d;
      assign eq9[k]  = (d == 4'd9);
      assign eq0[k]  = (d == 4'd0);
      assign lo9     = &(eq9 | ~LOW_MASK);
      assign lo0     = &(eq0 | ~LOW_MASK);
      assign lv      = load_val[k*BCD_W +: BCD_W];

      assign ld_val[k*BCD_W +: BCD_W] = (lv > 4'd9) ? 4'd9 : lv;

      always_comb begin
         cnt_nxt[k*BCD_W +: BCD_W] = d;
         if (up_dn && lo9) begin
            cnt_nxt[k*BCD_W +: BCD_W] = eq9[k] ? 4'd0 : d + 4'd1;
         end else if (!up_dn && lo0) begin
            cnt_nxt[k*BCD_W +: BCD_W] = eq0[k] ? 4'd9 : d - 4'd1;
         end
      end

      if (k == 0) begin : g_lsd
         assign blank_v[k] = 1'b0;
      end else begin : g_hsd
         assign blank_v[k] = (BLANK_LZ != 0) && (&(eq0 | LOW_MASK));
      end
   end

   assign wrap = up_dn ? (&eq9) : (&eq0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= '0;
         carry_out <= 1'b0;
      end else if (clear) begin
         count     <= '0;
         carry_out <= 1'b0;
      end else if (load) begin
         count     <= ld_val;
         carry_out <= 1'b0;
      end else if (cnt_tick && ena) begin
         count     <= cnt_nxt;
         carry_out <= wrap;
      end else begin
         carry_out <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_idx <= '0;
      end else if (scan_tick) begin
         scan_idx <= (scan_idx == IW'(N_DIGITS - 1)) ? '0 : scan_idx + IW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg     <= SEG_BLANK;
         dig_sel <= '1;
      end else begin
         seg     <= blank_v[scan_idx] ? SEG_BLANK : seg_decode(digs[scan_idx]);
         dig_sel <= ~(N_DIGITS'(1) << scan_idx);
      end
   end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter with short prescalers (count tick every 4 cycles, scan every 3).
module tb_bcd_scan_counter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ena = 1'b0;
   logic        up_dn = 1'b1;
   logic        clear = 1'b0;
   logic        load = 1'b0;
   logic [15:0] load_val = '0;
   logic [15:0] count;
   logic        carry_out;
   logic [6:0]  seg;
   logic [3:0]  dig_sel;

   int n_checks = 0;
   int n_fail   = 0;
   logic [1:0] m_pc;
   logic       found;

   bcd_scan_counter #(
      .N_DIGITS(4), .DIV_COUNT(3), .DIV_SCAN(2), .BLANK_LZ(1)
   ) dut (
      .clk(clk), .rst(rst), .ena(ena), .up_dn(up_dn), .clear(clear), .load(load),
      .load_val(load_val), .count(count), .carry_out(carry_out), .seg(seg), .dig_sel(dig_sel)
   );

   always #5 clk = ~clk;

   // Reference count-prescaler phase: a count edge is the one after which m_pc reads 0.
   always @(posedge clk or posedge rst) begin
      if (rst) m_pc <= 2'd0;
      else     m_pc <= m_pc + 2'd1;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ctick();
      step();
      for (int i = 0; i < 8 && m_pc != 2'd0; i++) step();
   endtask

   initial begin
      // Reset
      repeat (3) @(posedge clk);
      #1;
      check("rst_count", count, 16'h0000);
      check("rst_seg", {9'd0, seg}, 16'h007F);
      check("rst_dig_sel", {12'd0, dig_sel}, 16'h000F);
      check("rst_carry", {15'd0, carry_out}, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      step();
      check("zero_digit0_seg", {9'd0, seg}, 16'h0040);
      check("zero_digit0_sel", {12'd0, dig_sel}, 16'h000E);

      // Up wrap
      ena = 1'b1; up_dn = 1'b1; load_val = 16'h9998; load = 1'b1;
      step();
      load = 1'b0;
      check("up_load", count, 16'h9998);
      wait_ctick();
      check("up_tick1", count, 16'h9999);
      check("up_tick1_carry", {15'd0, carry_out}, 16'h0000);
      wait_ctick();
      check("up_wrap", count, 16'h0000);
      check("up_wrap_carry", {15'd0, carry_out}, 16'h0001);
      step();
      check("up_carry_drop", {15'd0, carry_out}, 16'h0000);

      // Down borrow chain
      up_dn = 1'b0; load_val = 16'h1000; load = 1'b1;
      step();
      load = 1'b0;
      wait_ctick();
      check("dn_borrow", count, 16'h0999);
      wait_ctick();
      check("dn_tick2", count, 16'h0998);
      repeat (998) wait_ctick();
      check("dn_zero", count, 16'h0000);
      check("dn_zero_carry", {15'd0, carry_out}, 16'h0000);
      wait_ctick();
      check("dn_wrap", count, 16'h9999);
      check("dn_wrap_carry", {15'd0, carry_out}, 16'h0001);
      step();
      check("dn_carry_drop", {15'd0, carry_out}, 16'h0000);

      // Load clamp, then clear beating load
      ena = 1'b0; load_val = 16'hA3F1; load = 1'b1;
      step();
      check("load_clamp", count, 16'h9391);
      check("load_carry", {15'd0, carry_out}, 16'h0000);
      clear = 1'b1;
      step();
      clear = 1'b0; load = 1'b0;
      check("clear_prio", count, 16'h0000);
      check("clear_carry", {15'd0, carry_out}, 16'h0000);

      // Scan with leading-zero blanking
      load_val = 16'h0042; load = 1'b1;
      step();
      load = 1'b0;
      step();
      step();
      found = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (dig_sel === 4'b1110) begin
            found = 1'b1;
            break;
         end
         step();
      end
      check("scan_sync", {15'd0, found}, 16'h0001);
      check("scan_d0_sel", {12'd0, dig_sel}, 16'h000E);
      check("scan_d0_seg", {9'd0, seg}, 16'h0024);
      repeat (3) step();
      check("scan_d1_sel", {12'd0, dig_sel}, 16'h000D);
      check("scan_d1_seg", {9'd0, seg}, 16'h0019);
      repeat (3) step();
      check("scan_d2_sel", {12'd0, dig_sel}, 16'h000B);
      check("scan_d2_seg", {9'd0, seg}, 16'h007F);
      repeat (3) step();
      check("scan_d3_sel", {12'd0, dig_sel}, 16'h0007);
      check("scan_d3_seg", {9'd0, seg}, 16'h007F);
      repeat (3) step();
      check("scan_wrap_sel", {12'd0, dig_sel}, 16'h000E);

      // Hold with ena low, then one enabled tick
      up_dn = 1'b1;
      repeat (10) wait_ctick();
      check("hold_count", count, 16'h0042);
      ena = 1'b1;
      wait_ctick();
      check("ena_count", count, 16'h0043);
      ena = 1'b0;

      // Asynchronous reset between edges
      #2;
      rst = 1'b1;
      #1;
      check("arst_count", count, 16'h0000);
      check("arst_seg", {9'd0, seg}, 16'h007F);
      check("arst_dig_sel", {12'd0, dig_sel}, 16'h000F);
      check("arst_carry", {15'd0, carry_out}, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
